stream_averager: RTL and testbench

Parametrised single-clock averaging stage: accepts a stream of unsigned samples and emits the mean of every 2^LOG2_N samples, either as a block average or as a sliding-window average. It sits downstream of the sample FIFO read side and replaces the fixed four-sample divider. Input and output use valid/ready handshakes with backpressure.

---
 rtl/stream_averager.sv | 142 ++++++++++++++
 tb/tb_stream_averager.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stream_averager.sv
`default_nettype none
// ============================================================================
// Module      : stream_averager
// Description : Mean of every 2^LOG2_N unsigned samples, as a block or a
//               sliding-window average, with valid/ready on both sides.
//               Optional macro STREAM_AVERAGER_ROUND_EN selects round-half-up.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_averager #(
    parameter int DATA_W  = 8,
    parameter int LOG2_N  = 2,
    parameter int SLIDING = 0
) (
    input  logic              CLKin,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    input  logic              data_ready_out
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int N     = 1 << LOG2_N;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);
`ifdef STREAM_AVERAGER_ROUND_EN
    localparam logic [ACC_W-1:0] C_ROUND = ACC_W'(1) << (LOG2_N - 1);
`else
    localparam logic [ACC_W-1:0] C_ROUND = '0;
`endif

    logic              w_accept;
    logic              w_take;
    logic              w_last;
    logic              w_load;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_rounded;
    logic [ACC_W-1:0]  w_avg;

    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;

    assign data_ready     = !r_valid_out || data_ready_out;
    assign data_out       = r_data_out;
    assign data_valid_out = r_valid_out;

    // clear discards a coincident sample, so it never reaches the datapath
    assign w_accept  = data_valid && data_ready;
    assign w_take    = w_accept && !clear;
    assign w_load    = w_take && w_last;
    assign w_rounded = w_sum + C_ROUND;
    assign w_avg     = w_rounded >> LOG2_N;

    generate
        if (SLIDING == 0) begin : g_block
            logic [ACC_W-1:0] r_acc;
            logic [CNT_W-1:0] r_cnt;

            assign w_sum  = r_acc + ACC_W'(data_in);
            assign w_last = (r_cnt == C_LAST);

            always_ff @(posedge CLKin or negedge reset) begin
                if (!reset) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else if (clear) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else if (w_take) begin
                    if (w_last) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end else begin : g_sliding
            localparam logic [CNT_W-1:0] C_N = CNT_W'(N);

            logic [DATA_W-1:0] r_hist [N];
            logic [LOG2_N-1:0] r_wptr;
            logic [ACC_W-1:0]  r_acc;
            logic [CNT_W-1:0]  r_cnt;

            // Modular arithmetic keeps the running sum exact despite the subtract
            assign w_sum  = r_acc + ACC_W'(data_in) - ACC_W'(r_hist[r_wptr]);
            assign w_last = (r_cnt >= C_LAST);

            always_ff @(posedge CLKin or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < N; i++) begin
                        r_hist[i] <= '0;
                    end
                    r_wptr <= '0;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end else if (clear) begin
                    for (int i = 0; i < N; i++) begin
                        r_hist[i] <= '0;
                    end
                    r_wptr <= '0;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end else if (w_take) begin
                    r_hist[r_wptr] <= data_in;
                    r_wptr         <= r_wptr + LOG2_N'(1);
                    r_acc          <= w_sum;
                    if (r_cnt != C_N) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge CLKin or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else if (w_load) begin
            r_data_out  <= w_avg[DATA_W-1:0];
            r_valid_out <= 1'b1;
        end else if (r_valid_out && data_ready_out) begin
            r_valid_out <= 1'b0;
        end
    end

    // A full-scale window plus rounding must still fit in DATA_W bits
    always_ff @(posedge CLKin) begin
        if (reset && w_load) begin
            assert (w_avg < (ACC_W'(1) << DATA_W));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_averager.sv
`default_nettype none
// Testbench for stream_averager: block-mode vector table plus hand-written
// reset, clear and sliding-window sequences.
module tb_stream_averager;

`ifdef STREAM_AVERAGER_ROUND_EN
    localparam bit C_RND = 1'b1;
`else
    localparam bit C_RND = 1'b0;
`endif
    localparam int E1 = C_RND ? 26 : 25;   // (10+20+30+42)/4
    localparam int E2 = C_RND ? 3 : 2;     // (1+2+3+4)/4

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       b_rst_n, b_clear, b_valid, b_ready, b_vout, b_rdy_out;
    logic [7:0] b_din, b_dout;
    logic       s_rst_n, s_clear, s_valid, s_ready, s_vout, s_rdy_out;
    logic [7:0] s_din, s_dout;

    stream_averager #(.DATA_W(8), .LOG2_N(2), .SLIDING(0)) u_blk (
        .CLKin(clk), .reset(b_rst_n), .clear(b_clear),
        .data_in(b_din), .data_valid(b_valid), .data_ready(b_ready),
        .data_out(b_dout), .data_valid_out(b_vout), .data_ready_out(b_rdy_out)
    );

    stream_averager #(.DATA_W(8), .LOG2_N(2), .SLIDING(1)) u_sld (
        .CLKin(clk), .reset(s_rst_n), .clear(s_clear),
        .data_in(s_din), .data_valid(s_valid), .data_ready(s_ready),
        .data_out(s_dout), .data_valid_out(s_vout), .data_ready_out(s_rdy_out)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit       v;
        bit [7:0] d;
        bit       ro;
        bit       clr;
        bit       evo;
        int       edo;
        bit       erdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input int d, input bit ro, input bit clr,
                       input bit evo, input int edo, input bit erdy);
        vec_t r;
        r.v = v; r.d = 8'(d); r.ro = ro; r.clr = clr;
        r.evo = evo; r.edo = edo; r.erdy = erdy;
        tbl.push_back(r);
    endtask

    int sld_in  [6] = '{4, 8, 12, 16, 20, 24};
    int sld_exp [6] = '{0, 0, 0, 0, 10, 14};

    initial begin
        b_rst_n = 0; b_clear = 0; b_valid = 0; b_din = 0; b_rdy_out = 1;
        s_rst_n = 0; s_clear = 0; s_valid = 0; s_din = 0; s_rdy_out = 1;

        // Expected outputs are those visible before the edge that applies the row
        add(1, 10, 1, 0, 0, 0, 1);
        add(1, 20, 1, 0, 0, 0, 1);
        add(1, 30, 1, 0, 0, 0, 1);
        add(1, 42, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 1, E1, 1);
        add(0, 0, 1, 0, 0, E1, 1);
        for (int j = 0; j < 8; j++)
            add(1, 255, 1, 0, (j == 4), (j < 4) ? E1 : 255, 1);
        add(0, 0, 1, 0, 1, 255, 1);
        add(0, 0, 1, 0, 0, 255, 1);
        for (int j = 1; j <= 4; j++) add(1, j, 1, 0, 0, 255, 1);
        add(1, 99, 0, 0, 1, E2, 0);
        add(1, 77, 0, 0, 1, E2, 0);
        add(0, 0, 1, 0, 1, E2, 1);
        add(0, 0, 1, 0, 0, E2, 1);
        for (int j = 0; j < 4; j++) add(1, 8, 1, 0, 0, E2, 1);
        add(0, 0, 1, 0, 1, 8, 1);
        add(0, 0, 1, 0, 0, 8, 1);
        for (int j = 0; j < 4; j++) add(1, 6, 1, 0, 0, 8, 1);
        add(0, 0, 0, 1, 1, 6, 0);
        add(0, 0, 0, 0, 1, 6, 0);
        add(1, 7, 1, 0, 1, 6, 1);
        add(1, 7, 1, 0, 0, 6, 1);
        add(1, 200, 1, 1, 0, 6, 1);
        for (int j = 0; j < 4; j++) add(1, 5, 1, 0, 0, 6, 1);
        add(0, 0, 1, 0, 1, 5, 1);
        add(0, 0, 1, 0, 0, 5, 1);

        repeat (2) @(negedge clk);
        #2;
        chk("reset b_vout", b_vout, 0);
        chk("reset b_dout", b_dout, 0);
        chk("reset b_ready", b_ready, 1);
        chk("reset s_vout", s_vout, 0);
        chk("reset s_dout", s_dout, 0);
        @(negedge clk);
        b_rst_n = 1; s_rst_n = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            b_valid = tbl[i].v; b_din = tbl[i].d;
            b_rdy_out = tbl[i].ro; b_clear = tbl[i].clr;
            #2;
            chk($sformatf("vec%0d vout", i), b_vout, tbl[i].evo);
            chk($sformatf("vec%0d dout", i), b_dout, tbl[i].edo);
            chk($sformatf("vec%0d ready", i), b_ready, tbl[i].erdy);
        end

        // Reset mid-window: partial 100s must vanish
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b_valid = 1; b_din = 100; b_rdy_out = 1; b_clear = 0;
            #2 chk("rst pre vout", b_vout, 0);
        end
        @(negedge clk);
        b_valid = 0;
        #1 b_rst_n = 0;
        #1;
        chk("rst async vout", b_vout, 0);
        chk("rst async dout", b_dout, 0);
        chk("rst async ready", b_ready, 1);
        @(negedge clk);
        b_rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_valid = 1; b_din = 1;
            #2 chk($sformatf("rst ones%0d vout", k), b_vout, 0);
        end
        @(negedge clk);
        b_valid = 0;
        #2;
        chk("rst result vout", b_vout, 1);
        chk("rst result dout", b_dout, 1);

        // Sliding window warm-up and steady state
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s_valid = 1; s_din = 8'(sld_in[k]);
            #2;
            chk($sformatf("sld%0d vout", k), s_vout, (k >= 4) ? 1 : 0);
            if (k >= 4) chk($sformatf("sld%0d dout", k), s_dout, sld_exp[k]);
        end
        @(negedge clk);
        s_valid = 0;
        #2;
        chk("sld last vout", s_vout, 1);
        chk("sld last dout", s_dout, 18);
        @(negedge clk);
        #2 chk("sld idle vout", s_vout, 0);

        // Sliding clear with coincident sample, then a fresh warm-up
        @(negedge clk);
        s_clear = 1; s_valid = 1; s_din = 50;
        @(negedge clk);
        s_clear = 0;
        for (int k = 0; k < 4; k++) begin
            s_din = 2;
            #2 chk($sformatf("sld clr%0d vout", k), s_vout, 0);
            @(negedge clk);
        end
        s_valid = 0;
        #2;
        chk("sld clr result vout", s_vout, 1);
        chk("sld clr result dout", s_dout, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
